jam_cost_arb: RTL
=================

JAM_COST_ARB -- requirements
Module: jam_cost_arb

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 8, meaning the maximum number of cost reads per grant (one per worker).
REQ-002 SHALL have port CLK  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N  input  1  meaning an asynchronous, active-low reset.
REQ-004 SHALL have ports REQ0, REQ1  input  1 each  meaning requester x wants a cost-table read this cycle.
REQ-005 SHALL have ports LAST0, LAST1  input  1 each  meaning this beat is requester x's final read of its burst.
REQ-006 SHALL have ports W0, J0, W1, J1  input  3 each  meaning the worker and job index of requester x.
REQ-007 SHALL have ports GNT0, GNT1  output  1 each  meaning requester x owns the cost table (registered).
REQ-008 SHALL have ports W, J  output  3 each  meaning the registered address driven to the shared cost table.
REQ-009 SHALL have port Cost  input  7  meaning cost-table data, combinationally valid for the current W/J.
REQ-010 SHALL have ports RVALID0, RVALID1  output  1 each  meaning RDATA belongs to requester x this cycle.
REQ-011 SHALL have port RDATA  output  7  meaning the registered cost returned.
REQ-012 SHALL have port ERR  output  1  meaning a one-cycle pulse on a forced release.

Function
REQ-013 SHALL implement the FSM states IDLE, OWN0 and OWN1, with GNTx = (state == OWNx).
REQ-014 SHALL leave IDLE as follows: only REQx set -> OWNx; both set -> the requester other than rr_last (the round-robin pointer); neither set -> stay in IDLE.
REQ-015 SHALL treat a cycle with REQx & GNTx as a beat: W <= Wx and J <= Jx at that edge, and the beat counter increments.
REQ-016 SHALL sample Cost into RDATA on the edge after address launch and pulse RVALIDx, giving a beat-to-RVALID latency of exactly 2 cycles.
REQ-017 SHALL sustain one beat per cycle, with overlapping responses pipelined in order.
REQ-018 SHALL, while in OWNx with REQx low, hold the grant, issue no beat, and leave W/J unchanged.
REQ-019 SHALL, on a beat with LASTx, set rr_last <= x, clear the beat counter, and go to OWN(other) if REQ(other) is set, otherwise to IDLE, with no idle turnaround on a handoff.
REQ-020 SHALL, on the MAX_BEATS-th beat without LASTx, release exactly as if LASTx were set and pulse ERR for one cycle.
REQ-021 SHALL ignore LASTx, Wx and Jx from the requester that is not granted.
REQ-022 SHALL never assert GNT0 and GNT1 together, nor RVALID0 and RVALID1 together.
REQ-023 SHALL compute the beat counter as 4 bits, saturating logic not required because release occurs at MAX_BEATS.

Reset
REQ-024 SHALL, on RST_N low, asynchronously force: state=IDLE, rr_last=1 (REQ0 wins the first tie), GNT0=GNT1=0, W=J=0, RDATA=0, RVALID0=RVALID1=0, ERR=0, beat counter=0.
REQ-025 SHALL discard in-flight responses on a mid-burst reset, with no RVALID after deassertion until a new beat occurs.
REQ-026 SHALL allow the first grant no earlier than the second rising CLK edge after RST_N rises.

Structure
REQ-027 SHALL place the state encoding (IDLE/OWN0/OWN1), MAX_BEATS default, and W/J/Cost widths in shared package jam_pkg.
REQ-028 SHALL factor the two-way round-robin choice into sub-module jam_rr_pick (inputs req[1:0], rr_last; output pick), with everything else in jam_cost_arb.

Verification
REQ-029 SHALL cover: REQ0 only, 8 beats W0=0..7, J0=7..0, LAST0 on 8th, table Cost=W*8+J -> GNT0 1 cycle after REQ0, RVALID0 ×8 with RDATA 7,14,...,56, then IDLE.
REQ-030 SHALL cover: REQ0 and REQ1 rise together after reset -> GNT0 first; LAST0 -> GNT1 on the next cycle, zero gap; the next tie -> GNT0.
REQ-031 SHALL cover: REQ1 owner drops REQ1 for 3 cycles mid-burst -> GNT1 held, no RVALID1 gap-fill, W/J stable, burst resumes.
REQ-032 SHALL cover: REQ0 issues 8 beats with LAST0 never set -> ERR pulses the cycle after the 8th beat, GNT0 drops, and a pending REQ1 is granted.
REQ-033 SHALL cover: RST_N low 2 cycles after a beat -> RVALID never appears; all outputs 0; the next tie grants REQ0.
REQ-034 SHALL check on every cycle, by assertion: mutual exclusion of GNT and RVALID, and the 2-cycle latency.

Source files
------------

// File: rtl/jam_pkg.sv
// -----------------------------------------------------------------------------
// jam_pkg
// Shared definitions for the cost-table arbiter: arbiter state encoding,
// default burst limit and the worker/job index and cost data widths.
// -----------------------------------------------------------------------------
package jam_pkg;

    // Default maximum number of cost reads per grant (one per worker).
    localparam int unsigned JAM_MAX_BEATS = 8;

    // Worker / job index width and cost data width.
    localparam int unsigned JAM_IDX_W  = 3;
    localparam int unsigned JAM_COST_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } jam_state_e;

endpackage

// File: rtl/jam_rr_pick.sv
// -----------------------------------------------------------------------------
// jam_rr_pick
// Two-way round-robin choice.
//   req[1:0] : requests from requester 1 and 0
//   rr_last  : requester that most recently finished a burst
//   pick     : chosen requester (0 or 1); only meaningful when req != 0
// -----------------------------------------------------------------------------
module jam_rr_pick (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic       pick
);

    // On a tie the requester that did not go last wins; otherwise the single
    // active requester wins.
    assign pick = (req == 2'b11) ? ~rr_last : req[1];

endmodule

// File: rtl/jam_cost_arb.sv
// -----------------------------------------------------------------------------
// jam_cost_arb
// Arbitrates two requesters for a shared cost table. The owner issues one
// read (beat) per cycle while its REQ is high; each beat launches a registered
// W/J address and the table data comes back registered on RDATA two cycles
// after the beat, tagged by RVALID0/RVALID1. A burst ends on LASTx, or is
// forcibly ended after MAX_BEATS beats with a one-cycle ERR pulse.
// Ports:
//   CLK, RST_N          : clock, asynchronous active-low reset
//   REQx, LASTx, Wx, Jx : requester x read request, final-beat flag, address
//   GNTx                : requester x owns the table (registered)
//   W, J                : registered address to the cost table
//   Cost                : table data for the current W/J (combinational)
//   RVALIDx, RDATA      : registered read response and its owner
//   ERR                 : forced-release pulse
// -----------------------------------------------------------------------------
module jam_cost_arb
    import jam_pkg::*;
#(
    parameter int unsigned MAX_BEATS = JAM_MAX_BEATS
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  REQ0,
    input  logic                  REQ1,
    input  logic                  LAST0,
    input  logic                  LAST1,
    input  logic [JAM_IDX_W-1:0]  W0,
    input  logic [JAM_IDX_W-1:0]  J0,
    input  logic [JAM_IDX_W-1:0]  W1,
    input  logic [JAM_IDX_W-1:0]  J1,
    output logic                  GNT0,
    output logic                  GNT1,
    output logic [JAM_IDX_W-1:0]  W,
    output logic [JAM_IDX_W-1:0]  J,
    input  logic [JAM_COST_W-1:0] Cost,
    output logic                  RVALID0,
    output logic                  RVALID1,
    output logic [JAM_COST_W-1:0] RDATA,
    output logic                  ERR
);

    localparam logic [3:0] LAST_BEAT_CNT = 4'(MAX_BEATS - 1);

    jam_state_e            r_state;
    jam_state_e            w_state_nxt;
    logic                  r_ready;
    logic                  r_rr_last;
    logic [3:0]            r_cnt;
    logic [JAM_IDX_W-1:0]  r_w;
    logic [JAM_IDX_W-1:0]  r_j;
    logic                  r_aval0;
    logic                  r_aval1;
    logic                  r_rvalid0;
    logic                  r_rvalid1;
    logic [JAM_COST_W-1:0] r_rdata;
    logic                  r_err;

    logic                  w_own0;
    logic                  w_own1;
    logic                  w_beat0;
    logic                  w_beat1;
    logic                  w_beat;
    logic                  w_last;
    logic                  w_at_max;
    logic                  w_release;
    logic                  w_forced;
    logic                  w_pick;
    logic [JAM_IDX_W-1:0]  w_addr_w;
    logic [JAM_IDX_W-1:0]  w_addr_j;

    jam_rr_pick u_rr_pick (
        .req     ({REQ1, REQ0}),
        .rr_last (r_rr_last),
        .pick    (w_pick)
    );

    assign w_own0    = (r_state == OWN0);
    assign w_own1    = (r_state == OWN1);
    assign w_beat0   = w_own0 & REQ0;
    assign w_beat1   = w_own1 & REQ1;
    assign w_beat    = w_beat0 | w_beat1;
    // Only the owner's LAST/W/J are looked at.
    assign w_last    = w_own1 ? LAST1 : LAST0;
    assign w_addr_w  = w_own1 ? W1 : W0;
    assign w_addr_j  = w_own1 ? J1 : J0;
    assign w_at_max  = (r_cnt == LAST_BEAT_CNT);
    assign w_release = w_beat & (w_last | w_at_max);
    assign w_forced  = w_beat & w_at_max & ~w_last;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            // r_ready holds off the first grant until the second edge after reset.
            IDLE: if (r_ready && (REQ0 || REQ1)) w_state_nxt = w_pick ? OWN1 : OWN0;
            OWN0: if (w_release) w_state_nxt = REQ1 ? OWN1 : IDLE;
            OWN1: if (w_release) w_state_nxt = REQ0 ? OWN0 : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_ready   <= 1'b0;
            r_rr_last <= 1'b1;
            r_cnt     <= 4'd0;
            r_w       <= '0;
            r_j       <= '0;
            r_aval0   <= 1'b0;
            r_aval1   <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= 1'b1;
            if (w_release) begin
                r_rr_last <= w_own1;
            end
            if (w_beat) begin
                r_w   <= w_addr_w;
                r_j   <= w_addr_j;
                r_cnt <= w_release ? 4'd0 : r_cnt + 4'd1;
            end
            // Stage 1: address launched; stage 2: table data captured.
            r_aval0   <= w_beat0;
            r_aval1   <= w_beat1;
            r_rvalid0 <= r_aval0;
            r_rvalid1 <= r_aval1;
            if (r_aval0 || r_aval1) begin
                r_rdata <= Cost;
            end
            r_err <= w_forced;
        end
    end

    assign GNT0    = w_own0;
    assign GNT1    = w_own1;
    assign W       = r_w;
    assign J       = r_j;
    assign RVALID0 = r_rvalid0;
    assign RVALID1 = r_rvalid1;
    assign RDATA   = r_rdata;
    assign ERR     = r_err;

endmodule
